// File: rtl/rftpu_tile_scheduler.sv
// rtl/rftpu_tile_scheduler.sv - job queue, round-robin tile dispatch, per-tile watchdog and completion return
module rftpu_tile_scheduler #(
  parameter int TILE_COUNT     = 64,
  parameter int TILE_IDX_W     = $clog2(TILE_COUNT),
  parameter int JOB_ID_W       = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [JOB_ID_W-1:0]   job_id,
  output logic [TILE_COUNT-1:0] tile_start,
  input  logic [TILE_COUNT-1:0] tile_done,
  input  logic [TILE_COUNT-1:0] fault_clr,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [TILE_IDX_W-1:0] cpl_tile,
  output logic [JOB_ID_W-1:0]   cpl_job_id,
  output logic                  cpl_timeout,
  output logic [TILE_COUNT-1:0] fault_mask,
  output logic [TILE_IDX_W:0]   inflight_count,
  output logic                  idle
);

  typedef enum logic [1:0] {
    T_FREE  = 2'd0,
    T_RUN   = 2'd1,
    T_CPL   = 2'd2,
    T_FAULT = 2'd3
  } tile_state_e;

  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  // Job queue storage and control
  logic [JOB_ID_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]      wr_ptr_q;
  logic [FAW-1:0]      rd_ptr_q;
  logic [FAW:0]        fifo_cnt_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [JOB_ID_W-1:0] fifo_head;

  // Per-tile state
  tile_state_e         st_q  [TILE_COUNT];
  tile_state_e         st_d  [TILE_COUNT];
  logic [WDW-1:0]      wd_q  [TILE_COUNT];
  logic [WDW-1:0]      wd_d  [TILE_COUNT];
  logic [JOB_ID_W-1:0] job_q [TILE_COUNT];
  logic [JOB_ID_W-1:0] job_d [TILE_COUNT];
  logic [TILE_COUNT-1:0] to_q;
  logic [TILE_COUNT-1:0] to_d;
  logic [TILE_COUNT-1:0] start_q;
  logic [TILE_COUNT-1:0] start_d;
  logic [TILE_COUNT-1:0] fault_q;
  logic [TILE_COUNT-1:0] fault_d;
  logic [TILE_IDX_W:0]   inflight_q;
  logic [TILE_IDX_W:0]   inflight_d;

  // Dispatch selection
  logic [TILE_IDX_W-1:0] rr_ptr_q;
  logic [TILE_IDX_W-1:0] scan_idx;
  logic [TILE_IDX_W-1:0] disp_sel;
  logic                  disp_found;
  logic                  dispatch;

  // Completion register and selection
  logic                  cpl_valid_q;
  logic [TILE_IDX_W-1:0] cpl_tile_q;
  logic [JOB_ID_W-1:0]   cpl_job_q;
  logic                  cpl_to_q;
  logic                  cpl_hs;
  logic                  cand_found;
  logic [TILE_IDX_W-1:0] cand_sel;
  logic                  cpl_load;

  assign fifo_full  = (fifo_cnt_q == (FAW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign job_ready  = !rst && !fifo_full;
  assign fifo_push  = job_valid && job_ready;
  assign fifo_pop   = dispatch;
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // Queue data write; contents need no reset since the count gates every read
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q] <= job_id;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= (wr_ptr_q == FAW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + FAW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= (rd_ptr_q == FAW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + FAW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (FAW+1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (FAW+1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // First FREE tile searching upward from the round-robin pointer, wrapping
  always_comb begin
    disp_found = 1'b0;
    disp_sel   = '0;
    scan_idx   = '0;
    for (int i = 0; i < TILE_COUNT; i++) begin
      scan_idx = rr_ptr_q + TILE_IDX_W'(i);
      if (!disp_found && st_q[scan_idx] == T_FREE) begin
        disp_found = 1'b1;
        disp_sel   = scan_idx;
      end
    end
  end

  assign dispatch = en && !fifo_empty && disp_found;

  // Lowest-index CPL tile not already held in the completion register
  always_comb begin
    cand_found = 1'b0;
    cand_sel   = '0;
    for (int t = TILE_COUNT-1; t >= 0; t--) begin
      if (st_q[t] == T_CPL && !(cpl_valid_q && cpl_tile_q == TILE_IDX_W'(t))) begin
        cand_found = 1'b1;
        cand_sel   = TILE_IDX_W'(t);
      end
    end
  end

  assign cpl_hs   = cpl_valid_q && cpl_ready;
  assign cpl_load = (!cpl_valid_q || cpl_hs) && cand_found;

  // Per-tile next state, watchdog, and the registered summary counts
  always_comb begin
    inflight_d = '0;
    fault_d    = '0;
    start_d    = '0;
    to_d       = to_q;
    for (int t = 0; t < TILE_COUNT; t++) begin
      st_d[t]  = st_q[t];
      wd_d[t]  = wd_q[t];
      job_d[t] = job_q[t];
      case (st_q[t])
        T_FREE: begin
          if (dispatch && disp_sel == TILE_IDX_W'(t)) begin
            st_d[t]    = T_RUN;
            wd_d[t]    = '0;
            to_d[t]    = 1'b0;
            job_d[t]   = fifo_head;
            start_d[t] = 1'b1;
          end
        end
        T_RUN: begin
          if (start_q[t]) begin
            // Done during the start cycle itself does not count
            wd_d[t] = wd_q[t] + WDW'(1);
          end else if (tile_done[t]) begin
            st_d[t] = T_CPL;
            to_d[t] = 1'b0;
          end else if (wd_q[t] == WDW'(TIMEOUT_CYCLES)) begin
            st_d[t] = T_CPL;
            to_d[t] = 1'b1;
          end else begin
            wd_d[t] = wd_q[t] + WDW'(1);
          end
        end
        T_CPL: begin
          if (cpl_hs && cpl_tile_q == TILE_IDX_W'(t)) begin
            st_d[t] = cpl_to_q ? T_FAULT : T_FREE;
          end
        end
        default: begin
          if (fault_clr[t]) begin
            st_d[t] = T_FREE;
          end
        end
      endcase
      if (st_d[t] == T_RUN || st_d[t] == T_CPL) begin
        inflight_d = inflight_d + (TILE_IDX_W+1)'(1);
      end
      fault_d[t] = (st_d[t] == T_FAULT);
    end
  end

  // Tile state, watchdog, start pulse and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < TILE_COUNT; t++) begin
        st_q[t]  <= T_FREE;
        wd_q[t]  <= '0;
        job_q[t] <= '0;
      end
      to_q       <= '0;
      start_q    <= '0;
      fault_q    <= '0;
      inflight_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      for (int t = 0; t < TILE_COUNT; t++) begin
        st_q[t]  <= st_d[t];
        wd_q[t]  <= wd_d[t];
        job_q[t] <= job_d[t];
      end
      to_q       <= to_d;
      start_q    <= start_d;
      fault_q    <= fault_d;
      inflight_q <= inflight_d;
      if (dispatch) begin
        rr_ptr_q <= disp_sel + TILE_IDX_W'(1);
      end
    end
  end

  // Completion record register; reloads on the handshake cycle for back-to-back records
  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_valid_q <= 1'b0;
      cpl_tile_q  <= '0;
      cpl_job_q   <= '0;
      cpl_to_q    <= 1'b0;
    end else if (cpl_load) begin
      cpl_valid_q <= 1'b1;
      cpl_tile_q  <= cand_sel;
      cpl_job_q   <= job_q[cand_sel];
      cpl_to_q    <= to_q[cand_sel];
    end else if (cpl_hs) begin
      cpl_valid_q <= 1'b0;
    end
  end

  assign tile_start     = start_q;
  assign cpl_valid      = cpl_valid_q;
  assign cpl_tile       = cpl_tile_q;
  assign cpl_job_id     = cpl_job_q;
  assign cpl_timeout    = cpl_to_q;
  assign fault_mask     = fault_q;
  assign inflight_count = inflight_q;
  assign idle           = fifo_empty && (inflight_q == '0);

endmodule

// File: tb/tb_rftpu_tile_scheduler.sv
// tb/tb_rftpu_tile_scheduler.sv - scoreboard bench for rftpu_tile_scheduler
module tb_rftpu_tile_scheduler;

  localparam int TC = 4;
  localparam int IW = 2;
  localparam int JW = 8;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          job_valid;
  logic          job_ready;
  logic [JW-1:0] job_id;
  logic [TC-1:0] tile_start;
  logic [TC-1:0] tile_done;
  logic [TC-1:0] fault_clr;
  logic          cpl_valid;
  logic          cpl_ready;
  logic [IW-1:0] cpl_tile;
  logic [JW-1:0] cpl_job_id;
  logic          cpl_timeout;
  logic [TC-1:0] fault_mask;
  logic [IW:0]   inflight_count;
  logic          idle;

  typedef struct packed {
    logic [IW-1:0] tile;
    logic [JW-1:0] job;
    logic          to;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  rftpu_tile_scheduler #(
    .TILE_COUNT(TC), .TILE_IDX_W(IW), .JOB_ID_W(JW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
    .tile_start(tile_start), .tile_done(tile_done), .fault_clr(fault_clr),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tile(cpl_tile),
    .cpl_job_id(cpl_job_id), .cpl_timeout(cpl_timeout),
    .fault_mask(fault_mask), .inflight_count(inflight_count), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted completion record is compared against the oldest expected one
  always @(negedge clk) begin
    rec_t e;
    if (!rst && cpl_valid && cpl_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL record_unexpected: got tile=%0d job=%h to=%0d, required no record", cpl_tile, cpl_job_id, cpl_timeout);
      end else begin
        e = exp_q.pop_front();
        if ({cpl_tile, cpl_job_id, cpl_timeout} !== e) begin
          bad++;
          $display("FAIL record: got tile=%0d job=%h to=%0d, required tile=%0d job=%h to=%0d",
                   cpl_tile, cpl_job_id, cpl_timeout, e.tile, e.job, e.to);
        end
      end
    end
  end

  function automatic rec_t mk(input int t, input int j, input bit to);
    rec_t r;
    r.tile = IW'(t);
    r.job  = JW'(j);
    r.to   = to;
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_cycle(input logic v, input logic [JW-1:0] id);
    step();
    job_valid = v;
    job_id    = id;
    @(negedge clk);
  endtask

  task automatic do_reset;
    step();
    rst       = 1'b1;
    en        = 1'b1;
    job_valid = 1'b0;
    tile_done = '0;
    fault_clr = '0;
    cpl_ready = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: outstanding=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    step();
    @(negedge clk);
    total++;
    if (job_ready !== 1'b0) begin bad++; $display("FAIL reset_job_ready_in_rst: got %b, required 0", job_ready); end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({job_ready, tile_start, cpl_valid, cpl_tile, cpl_job_id, cpl_timeout} !== {1'b1, 4'b0, 1'b0, 2'd0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b start=%b cv=%b tile=%0d job=%h to=%b, required 1 0000 0 0 00 0",
               job_ready, tile_start, cpl_valid, cpl_tile, cpl_job_id, cpl_timeout);
    end
    total++;
    if ({fault_mask, inflight_count, idle} !== {4'b0, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_counts: got fault=%b inflight=%0d idle=%b, required 0000 0 1", fault_mask, inflight_count, idle);
    end
  endtask

  task automatic test_dispatch_walk;
    logic [TC-1:0] want;
    for (int k = 0; k < 8; k++) begin
      push_cycle(k < 4, JW'(8'h10 + k));
      want = (k >= 2 && k < 6) ? TC'(1 << (k - 2)) : '0;
      total++;
      if (tile_start !== want) begin bad++; $display("FAIL walk_start k=%0d: got %b, required %b", k, tile_start, want); end
      if (k < 4) begin
        total++;
        if (job_ready !== 1'b1) begin bad++; $display("FAIL walk_ready k=%0d: got %b, required 1", k, job_ready); end
      end
    end
    total++;
    if (inflight_count !== 3'd4 || idle !== 1'b0) begin
      bad++;
      $display("FAIL walk_inflight: got %0d idle=%b, required 4 idle=0", inflight_count, idle);
    end
  endtask

  task automatic test_two_done;
    logic [TC-1:0] want;
    step();
    tile_done = 4'b0101;
    exp_q.push_back(mk(0, 8'h10, 1'b0));
    exp_q.push_back(mk(2, 8'h12, 1'b0));
    @(negedge clk);
    step();
    tile_done = '0;
    @(negedge clk);
    total++;
    if (cpl_valid !== 1'b0) begin bad++; $display("FAIL two_done_early: got cpl_valid=%b, required 0", cpl_valid); end
    step();
    @(negedge clk);
    total++;
    if (cpl_valid !== 1'b1 || cpl_tile !== 2'd0) begin bad++; $display("FAIL two_done_first: got v=%b tile=%0d, required v=1 tile=0", cpl_valid, cpl_tile); end
    step();
    @(negedge clk);
    total++;
    if (cpl_valid !== 1'b1 || cpl_tile !== 2'd2) begin bad++; $display("FAIL two_done_second: got v=%b tile=%0d, required v=1 tile=2", cpl_valid, cpl_tile); end
    step();
    @(negedge clk);
    total++;
    if (cpl_valid !== 1'b0 || inflight_count !== 3'd2) begin
      bad++;
      $display("FAIL two_done_after: got v=%b inflight=%0d, required v=0 inflight=2", cpl_valid, inflight_count);
    end
    for (int k = 0; k < 5; k++) begin
      push_cycle(k < 2, JW'(8'h20 + k));
      want = (k == 2) ? 4'b0001 : (k == 3) ? 4'b0100 : 4'b0000;
      total++;
      if (tile_start !== want) begin bad++; $display("FAIL redispatch k=%0d: got %b, required %b", k, tile_start, want); end
    end
  endtask

  task automatic test_queue_full;
    int n;
    for (int k = 0; k < 6; k++) begin
      push_cycle(k < 4, JW'(8'h30 + k));
    end
    total++;
    if (inflight_count !== 3'd4) begin bad++; $display("FAIL qf_inflight: got %0d, required 4", inflight_count); end
    n = 0;
    for (int c = 0; c < 6; c++) begin
      push_cycle(1'b1, JW'(8'h40 + n));
      total++;
      if (job_ready !== (c < 4)) begin bad++; $display("FAIL qf_ready c=%0d: got %b, required %b", c, job_ready, (c < 4)); end
      if (job_ready) n++;
    end
    step();
    tile_done = 4'b0010;
    exp_q.push_back(mk(1, 8'h31, 1'b0));
    @(negedge clk);
    step();
    tile_done = '0;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    total++;
    if (tile_start !== 4'b0000) begin bad++; $display("FAIL qf_start_early: got %b, required 0000", tile_start); end
    step();
    @(negedge clk);
    total++;
    if (tile_start !== 4'b0010 || job_ready !== 1'b1) begin
      bad++;
      $display("FAIL qf_refill: got start=%b ready=%b, required 0010 1", tile_start, job_ready);
    end
    step();
    @(negedge clk);
    total++;
    if (job_ready !== 1'b0) begin bad++; $display("FAIL qf_full_again: got %b, required 0", job_ready); end
    step();
    job_valid = 1'b0;
    tile_done = 4'b0010;
    exp_q.push_back(mk(1, 8'h40, 1'b0));
    @(negedge clk);
    step();
    tile_done = '0;
    wait_drain();
  endtask

  task automatic test_watchdog;
    int s3;
    logic [TC-1:0] want;
    s3 = 0;
    for (int k = 0; k < 6; k++) begin
      push_cycle(k < 4, JW'(8'h50 + k));
      if (k == 5) begin
        total++;
        if (tile_start !== 4'b1000) begin bad++; $display("FAIL wd_start3: got %b, required 1000", tile_start); end
        s3 = cyc;
      end
    end
    step();
    tile_done = 4'b0111;
    exp_q.push_back(mk(0, 8'h50, 1'b0));
    exp_q.push_back(mk(1, 8'h51, 1'b0));
    exp_q.push_back(mk(2, 8'h52, 1'b0));
    exp_q.push_back(mk(3, 8'h53, 1'b1));
    @(negedge clk);
    step();
    tile_done = '0;
    @(negedge clk);
    while (cyc < s3 + TO + 1) begin
      step();
      @(negedge clk);
    end
    total++;
    if (cpl_valid !== 1'b0 || inflight_count !== 3'd1) begin
      bad++;
      $display("FAIL wd_s33: got v=%b inflight=%0d, required v=0 inflight=1", cpl_valid, inflight_count);
    end
    step();
    @(negedge clk);
    total++;
    if (cpl_valid !== 1'b1 || cpl_tile !== 2'd3 || cpl_timeout !== 1'b1) begin
      bad++;
      $display("FAIL wd_s34: got v=%b tile=%0d to=%b, required v=1 tile=3 to=1", cpl_valid, cpl_tile, cpl_timeout);
    end
    step();
    @(negedge clk);
    total++;
    if (fault_mask !== 4'b1000 || inflight_count !== 3'd0) begin
      bad++;
      $display("FAIL wd_fault: got mask=%b inflight=%0d, required 1000 0", fault_mask, inflight_count);
    end
    for (int k = 0; k < 6; k++) begin
      push_cycle(k < 4, JW'(8'h60 + k));
      want = (k == 2) ? 4'b0001 : (k == 3) ? 4'b0010 : (k == 4) ? 4'b0100 : 4'b0000;
      total++;
      if (tile_start !== want) begin bad++; $display("FAIL wd_skip k=%0d: got %b, required %b", k, tile_start, want); end
    end
    step();
    fault_clr = 4'b1000;
    @(negedge clk);
    step();
    fault_clr = '0;
    @(negedge clk);
    total++;
    if (fault_mask !== 4'b0000 || tile_start !== 4'b0000) begin
      bad++;
      $display("FAIL wd_clr: got mask=%b start=%b, required 0000 0000", fault_mask, tile_start);
    end
    step();
    @(negedge clk);
    total++;
    if (tile_start !== 4'b1000) begin bad++; $display("FAIL wd_clr_dispatch: got %b, required 1000", tile_start); end
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 4; k++) begin
      push_cycle(k < 2, JW'(8'h70 + k));
    end
    step();
    cpl_ready = 1'b0;
    tile_done = 4'b0011;
    exp_q.push_back(mk(0, 8'h70, 1'b0));
    exp_q.push_back(mk(1, 8'h71, 1'b0));
    @(negedge clk);
    step();
    tile_done = '0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      total++;
      if (cpl_valid !== 1'b1 || cpl_tile !== 2'd0 || cpl_job_id !== 8'h70) begin
        bad++;
        $display("FAIL bp_hold i=%0d: got v=%b tile=%0d job=%h, required 1 0 70", i, cpl_valid, cpl_tile, cpl_job_id);
      end
    end
    step();
    cpl_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    total++;
    if (cpl_valid !== 1'b1 || cpl_tile !== 2'd1 || cpl_job_id !== 8'h71) begin
      bad++;
      $display("FAIL bp_second: got v=%b tile=%0d job=%h, required 1 1 71", cpl_valid, cpl_tile, cpl_job_id);
    end
    wait_drain();
  endtask

  task automatic test_enable;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push_cycle(k == 0, 8'hA0);
      total++;
      if (tile_start !== 4'b0000) begin bad++; $display("FAIL en_hold k=%0d: got %b, required 0000", k, tile_start); end
    end
    step();
    en = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    total++;
    if (tile_start !== 4'b0001) begin bad++; $display("FAIL en_resume: got %b, required 0001", tile_start); end
    step();
    tile_done = 4'b0001;
    exp_q.push_back(mk(0, 8'hA0, 1'b0));
    @(negedge clk);
    step();
    tile_done = '0;
    wait_drain();
  endtask

  task automatic test_reset_midrun;
    int seen;
    for (int k = 0; k < 5; k++) begin
      push_cycle(k < 3, JW'(8'h80 + k));
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (job_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b, required 0", job_ready); end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({job_ready, tile_start, cpl_valid, fault_mask, inflight_count, idle} !== {1'b1, 4'b0, 1'b0, 4'b0, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL mid_rst_outputs: got ready=%b start=%b v=%b mask=%b inflight=%0d idle=%b, required 1 0000 0 0000 0 1",
               job_ready, tile_start, cpl_valid, fault_mask, inflight_count, idle);
    end
    step();
    tile_done = 4'b0111;
    @(negedge clk);
    step();
    tile_done = '0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      if (cpl_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mid_late_done: got %0d valid cycles, required 0", seen); end
    for (int k = 0; k < 3; k++) begin
      push_cycle(k == 0, 8'h90);
      if (k == 2) begin
        total++;
        if (tile_start !== 4'b0001) begin bad++; $display("FAIL mid_next_tile0: got %b, required 0001", tile_start); end
      end
    end
    step();
    tile_done = 4'b0001;
    exp_q.push_back(mk(0, 8'h90, 1'b0));
    @(negedge clk);
    step();
    tile_done = '0;
    wait_drain();
    step();
    @(negedge clk);
    total++;
    if (idle !== 1'b1 || inflight_count !== 3'd0) begin
      bad++;
      $display("FAIL final_idle: got idle=%b inflight=%0d, required 1 0", idle, inflight_count);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    job_valid = 1'b0;
    job_id    = '0;
    tile_done = '0;
    fault_clr = '0;
    cpl_ready = 1'b1;
    test_reset();
    test_dispatch_walk();
    test_two_done();
    do_reset();
    test_queue_full();
    do_reset();
    test_watchdog();
    do_reset();
    test_backpressure();
    do_reset();
    test_enable();
    do_reset();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
